// File: rtl/axi_lite_xbar.sv
// AXI4-Lite crossbar: NM masters to NS slaves, independent single-outstanding read and write
// paths, round-robin arbitration per path, DECERR for addresses that decode past the last slave.
module axi_lite_xbar #(
    parameter int unsigned NM      = 2,
    parameter int unsigned NS      = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned SEL_LSB = 28
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NM*AW-1:0]     m_araddr_i,
    input  logic [NM-1:0]        m_arvalid_i,
    output logic [NM-1:0]        m_arready_o,
    output logic [NM*DW-1:0]     m_rdata_o,
    output logic [NM*2-1:0]      m_rresp_o,
    output logic [NM-1:0]        m_rvalid_o,
    input  logic [NM-1:0]        m_rready_i,
    input  logic [NM*AW-1:0]     m_awaddr_i,
    input  logic [NM-1:0]        m_awvalid_i,
    output logic [NM-1:0]        m_awready_o,
    input  logic [NM*DW-1:0]     m_wdata_i,
    input  logic [NM*DW/8-1:0]   m_wstrb_i,
    input  logic [NM-1:0]        m_wvalid_i,
    output logic [NM-1:0]        m_wready_o,
    output logic [NM*2-1:0]      m_bresp_o,
    output logic [NM-1:0]        m_bvalid_o,
    input  logic [NM-1:0]        m_bready_i,
    output logic [NS*AW-1:0]     s_araddr_o,
    output logic [NS-1:0]        s_arvalid_o,
    input  logic [NS-1:0]        s_arready_i,
    input  logic [NS*DW-1:0]     s_rdata_i,
    input  logic [NS*2-1:0]      s_rresp_i,
    input  logic [NS-1:0]        s_rvalid_i,
    output logic [NS-1:0]        s_rready_o,
    output logic [NS*AW-1:0]     s_awaddr_o,
    output logic [NS-1:0]        s_awvalid_o,
    input  logic [NS-1:0]        s_awready_i,
    output logic [NS*DW-1:0]     s_wdata_o,
    output logic [NS*DW/8-1:0]   s_wstrb_o,
    output logic [NS-1:0]        s_wvalid_o,
    input  logic [NS-1:0]        s_wready_i,
    input  logic [NS*2-1:0]      s_bresp_i,
    input  logic [NS-1:0]        s_bvalid_i,
    output logic [NS-1:0]        s_bready_o
);
    localparam int unsigned SB = DW / 8;
    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned FW = AW - SEL_LSB;

    typedef enum logic [1:0] {RIdle, RAddr, RData, RErr} r_state_e;
    typedef enum logic [1:0] {WIdle, WAddr, WResp, WErr} w_state_e;

    // Rotate requests so bit 0 is the current priority holder, then take the lowest set bit.
    function automatic logic [IW-1:0] rr_pick(input logic [NM-1:0] req, input logic [IW-1:0] ptr);
        logic [2*NM-1:0] rot;
        logic [IW-1:0]   win;
        int unsigned     idx;
        rot = {req, req} >> ptr;
        win = ptr;
        for (int k = int'(NM) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = 32'(ptr) + 32'(k);
                if (idx >= NM) idx = idx - NM;
                win = IW'(idx);
            end
        end
        return win;
    endfunction

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
        return (32'(g) >= NM - 1) ? '0 : g + IW'(1);
    endfunction

    function automatic logic is_mapped(input logic [FW-1:0] sel);
        return 32'(sel) < NS;
    endfunction

    // ---------------- read path ----------------
    r_state_e        r_state_q, r_state_d;
    logic [IW-1:0]   r_grant_q, r_grant_d, r_ptr_q, r_ptr_d, r_win;
    logic [SW-1:0]   r_sel_q, r_sel_d;
    logic [AW-1:0]   r_addr_q, r_addr_d, r_win_addr;
    logic            r_s_arready, r_s_rvalid, r_m_rready, r_rv;
    logic [DW-1:0]   r_s_rdata, r_rd;
    logic [1:0]      r_s_rresp, r_rr;

    assign s_araddr_o = {NS{r_addr_q}};

    always_comb begin
        r_state_d   = r_state_q;
        r_grant_d   = r_grant_q;
        r_sel_d     = r_sel_q;
        r_addr_d    = r_addr_q;
        r_ptr_d     = r_ptr_q;
        m_arready_o = '0;
        m_rvalid_o  = '0;
        m_rdata_o   = '0;
        m_rresp_o   = '0;
        s_arvalid_o = '0;
        s_rready_o  = '0;
        r_rv        = 1'b0;
        r_rd        = '0;
        r_rr        = '0;
        r_win       = rr_pick(m_arvalid_i, r_ptr_q);
        r_win_addr  = '0;
        r_s_arready = 1'b0;
        r_s_rvalid  = 1'b0;
        r_s_rdata   = '0;
        r_s_rresp   = '0;
        r_m_rready  = 1'b0;
        for (int i = 0; i < int'(NM); i++) begin
            if (IW'(i) == r_win) r_win_addr = m_araddr_i[i*AW +: AW];
            if (IW'(i) == r_grant_q) r_m_rready = m_rready_i[i];
        end
        for (int j = 0; j < int'(NS); j++) begin
            if (SW'(j) == r_sel_q) begin
                r_s_arready = s_arready_i[j];
                r_s_rvalid  = s_rvalid_i[j];
                r_s_rdata   = s_rdata_i[j*DW +: DW];
                r_s_rresp   = s_rresp_i[j*2 +: 2];
            end
        end
        unique case (r_state_q)
            RIdle: begin
                // Gated by reset so no ready leaks out while the block is held in reset.
                if (rst_ni && (|m_arvalid_i)) begin
                    m_arready_o = NM'(1) << r_win;
                    r_grant_d   = r_win;
                    r_addr_d    = r_win_addr;
                    r_ptr_d     = rr_next(r_win);
                    r_sel_d     = SW'(r_win_addr[AW-1:SEL_LSB]);
                    r_state_d   = is_mapped(r_win_addr[AW-1:SEL_LSB]) ? RAddr : RErr;
                end
            end
            RAddr: begin
                s_arvalid_o = NS'(1) << r_sel_q;
                if (r_s_arready) r_state_d = RData;
            end
            RData: begin
                r_rv       = r_s_rvalid;
                r_rd       = r_s_rdata;
                r_rr       = r_s_rresp;
                s_rready_o = NS'(r_m_rready) << r_sel_q;
                if (r_s_rvalid && r_m_rready) r_state_d = RIdle;
            end
            RErr: begin
                r_rv = 1'b1;
                r_rr = 2'b11;
                if (r_m_rready) r_state_d = RIdle;
            end
            default: r_state_d = RIdle;
        endcase
        for (int i = 0; i < int'(NM); i++) begin
            if (IW'(i) == r_grant_q) begin
                m_rvalid_o[i]          = r_rv;
                m_rdata_o[i*DW +: DW]  = r_rd;
                m_rresp_o[i*2 +: 2]    = r_rr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= RIdle;
            r_grant_q <= '0;
            r_sel_q   <= '0;
            r_addr_q  <= '0;
            r_ptr_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_grant_q <= r_grant_d;
            r_sel_q   <= r_sel_d;
            r_addr_q  <= r_addr_d;
            r_ptr_q   <= r_ptr_d;
        end
    end

    // ---------------- write path ----------------
    w_state_e        w_state_q, w_state_d;
    logic [IW-1:0]   w_grant_q, w_grant_d, w_ptr_q, w_ptr_d, w_win;
    logic [SW-1:0]   w_sel_q, w_sel_d;
    logic [AW-1:0]   w_addr_q, w_addr_d, w_win_addr;
    logic [DW-1:0]   w_data_q, w_data_d, w_win_data;
    logic [SB-1:0]   w_strb_q, w_strb_d, w_win_strb;
    logic            w_aw_pend_q, w_aw_pend_d, w_w_pend_q, w_w_pend_d;
    logic [NM-1:0]   w_req;
    logic            w_s_awready, w_s_wready, w_s_bvalid, w_m_bready, w_bv;
    logic [1:0]      w_s_bresp, w_br;

    assign s_awaddr_o = {NS{w_addr_q}};
    assign s_wdata_o  = {NS{w_data_q}};
    assign s_wstrb_o  = {NS{w_strb_q}};
    assign w_req      = m_awvalid_i & m_wvalid_i;

    always_comb begin
        w_state_d   = w_state_q;
        w_grant_d   = w_grant_q;
        w_sel_d     = w_sel_q;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        w_ptr_d     = w_ptr_q;
        w_aw_pend_d = w_aw_pend_q;
        w_w_pend_d  = w_w_pend_q;
        m_awready_o = '0;
        m_wready_o  = '0;
        m_bvalid_o  = '0;
        m_bresp_o   = '0;
        s_awvalid_o = '0;
        s_wvalid_o  = '0;
        s_bready_o  = '0;
        w_bv        = 1'b0;
        w_br        = '0;
        w_win       = rr_pick(w_req, w_ptr_q);
        w_win_addr  = '0;
        w_win_data  = '0;
        w_win_strb  = '0;
        w_m_bready  = 1'b0;
        w_s_awready = 1'b0;
        w_s_wready  = 1'b0;
        w_s_bvalid  = 1'b0;
        w_s_bresp   = '0;
        for (int i = 0; i < int'(NM); i++) begin
            if (IW'(i) == w_win) begin
                w_win_addr = m_awaddr_i[i*AW +: AW];
                w_win_data = m_wdata_i[i*DW +: DW];
                w_win_strb = m_wstrb_i[i*SB +: SB];
            end
            if (IW'(i) == w_grant_q) w_m_bready = m_bready_i[i];
        end
        for (int j = 0; j < int'(NS); j++) begin
            if (SW'(j) == w_sel_q) begin
                w_s_awready = s_awready_i[j];
                w_s_wready  = s_wready_i[j];
                w_s_bvalid  = s_bvalid_i[j];
                w_s_bresp   = s_bresp_i[j*2 +: 2];
            end
        end
        unique case (w_state_q)
            WIdle: begin
                if (rst_ni && (|w_req)) begin
                    m_awready_o = NM'(1) << w_win;
                    m_wready_o  = NM'(1) << w_win;
                    w_grant_d   = w_win;
                    w_addr_d    = w_win_addr;
                    w_data_d    = w_win_data;
                    w_strb_d    = w_win_strb;
                    w_ptr_d     = rr_next(w_win);
                    w_sel_d     = SW'(w_win_addr[AW-1:SEL_LSB]);
                    w_aw_pend_d = 1'b1;
                    w_w_pend_d  = 1'b1;
                    w_state_d   = is_mapped(w_win_addr[AW-1:SEL_LSB]) ? WAddr : WErr;
                end
            end
            WAddr: begin
                // AW and W channels retire independently; leave once both have handshaken.
                s_awvalid_o = NS'(w_aw_pend_q) << w_sel_q;
                s_wvalid_o  = NS'(w_w_pend_q) << w_sel_q;
                if (w_s_awready) w_aw_pend_d = 1'b0;
                if (w_s_wready)  w_w_pend_d  = 1'b0;
                if ((!w_aw_pend_q || w_s_awready) && (!w_w_pend_q || w_s_wready)) begin
                    w_state_d = WResp;
                end
            end
            WResp: begin
                w_bv       = w_s_bvalid;
                w_br       = w_s_bresp;
                s_bready_o = NS'(w_m_bready) << w_sel_q;
                if (w_s_bvalid && w_m_bready) w_state_d = WIdle;
            end
            WErr: begin
                w_bv = 1'b1;
                w_br = 2'b11;
                if (w_m_bready) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
        for (int i = 0; i < int'(NM); i++) begin
            if (IW'(i) == w_grant_q) begin
                m_bvalid_o[i]       = w_bv;
                m_bresp_o[i*2 +: 2] = w_br;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q   <= WIdle;
            w_grant_q   <= '0;
            w_sel_q     <= '0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            w_ptr_q     <= '0;
            w_aw_pend_q <= 1'b0;
            w_w_pend_q  <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            w_grant_q   <= w_grant_d;
            w_sel_q     <= w_sel_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            w_ptr_q     <= w_ptr_d;
            w_aw_pend_q <= w_aw_pend_d;
            w_w_pend_q  <= w_w_pend_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Directed bench for axi_lite_xbar (2x2): the bench acts as both masters and both slaves,
// pushes expected data when it drives stimulus and pops it when the DUT delivers.
module tb_axi_lite_xbar;
    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SB = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NM*AW-1:0] m_araddr, m_awaddr;
    logic [NM*DW-1:0] m_rdata, m_wdata;
    logic [NM*SB-1:0] m_wstrb;
    logic [NM*2-1:0]  m_rresp, m_bresp;
    logic [NM-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [NM-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [NS*AW-1:0] s_araddr, s_awaddr;
    logic [NS*DW-1:0] s_rdata, s_wdata;
    logic [NS*SB-1:0] s_wstrb;
    logic [NS*2-1:0]  s_rresp, s_bresp;
    logic [NS-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NS-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

    always #5 clk = ~clk;

    axi_lite_xbar #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SEL_LSB(28)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_araddr_i(m_araddr), .m_arvalid_i(m_arvalid), .m_arready_o(m_arready),
        .m_rdata_o(m_rdata), .m_rresp_o(m_rresp), .m_rvalid_o(m_rvalid), .m_rready_i(m_rready),
        .m_awaddr_i(m_awaddr), .m_awvalid_i(m_awvalid), .m_awready_o(m_awready),
        .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb), .m_wvalid_i(m_wvalid), .m_wready_o(m_wready),
        .m_bresp_o(m_bresp), .m_bvalid_o(m_bvalid), .m_bready_i(m_bready),
        .s_araddr_o(s_araddr), .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
        .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready),
        .s_awaddr_o(s_awaddr), .s_awvalid_o(s_awvalid), .s_awready_i(s_awready),
        .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_wvalid_o(s_wvalid), .s_wready_i(s_wready),
        .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready)
    );

    int n_pass = 0;
    int n_chk  = 0;
    logic [31:0] exp_q[$];

    logic err_win = 1'b0;
    logic bp_win  = 1'b0;
    int   stray = 0, awv_cyc = 0, wv_cyc = 0, b_hs = 0;

    always @(negedge clk) begin
        if (err_win && ((|s_awvalid) || (|s_wvalid))) stray <= stray + 1;
        if (bp_win) begin
            awv_cyc <= awv_cyc + int'(s_awvalid[1]);
            wv_cyc  <= wv_cyc + int'(s_wvalid[1]);
            b_hs    <= b_hs + int'(m_bvalid[0] & m_bready[0]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic pop_chk(input string tag, input logic [63:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $error("FAIL %s: got %0h, want <nothing queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, {32'h0, e});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_inputs();
        m_araddr = '0; m_arvalid = '0; m_rready = '0;
        m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_bready = '0;
        s_arready = '0; s_rdata = '0; s_rresp = '0; s_rvalid = '0;
        s_awready = '0; s_wready = '0; s_bresp = '0; s_bvalid = '0;
    endtask

    // Zero-wait read: arready at cycle 0, s_arvalid at 1, m_rvalid at 2.
    task automatic rd_once(input int m, input logic [31:0] addr, input int s,
                           input logic [31:0] data, input string tag);
        m_araddr[m*AW +: AW] = addr;
        m_arvalid[m] = 1'b1;
        exp_q.push_back(data);
        #1 chk({tag, ".arready"}, 64'(m_arready), 64'(1 << m));
        tick();
        m_arvalid[m] = 1'b0;
        #1 chk({tag, ".s_arvalid"}, 64'(s_arvalid), 64'(1 << s));
        chk({tag, ".s_araddr"}, 64'(s_araddr[s*AW +: AW]), 64'(addr));
        s_arready[s] = 1'b1;
        tick();
        s_arready[s] = 1'b0;
        s_rvalid[s] = 1'b1;
        s_rdata[s*DW +: DW] = data;
        s_rresp[s*2 +: 2] = 2'b00;
        m_rready[m] = 1'b1;
        #1 chk({tag, ".m_rvalid"}, 64'(m_rvalid), 64'(1 << m));
        pop_chk({tag, ".rdata"}, 64'(m_rdata[m*DW +: DW]));
        chk({tag, ".rresp"}, 64'(m_rresp), 64'(0));
        tick();
        s_rvalid = '0;
        m_rready = '0;
        #1 chk({tag, ".idle"}, 64'(m_rvalid), 64'(0));
    endtask

    initial begin
        int gcnt0, gcnt1, m;
        logic [31:0] a;
        clr_inputs();
        rst_n = 1'b0;
        m_arvalid = '1;
        m_awvalid = '1;
        m_wvalid  = '1;
        #3;
        chk("rst.ready", 64'({m_arready, m_awready, m_wready}), 64'(0));
        chk("rst.valid", 64'({m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid, s_rready,
                              s_bready}), 64'(0));
        chk("rst.rdata", 64'(m_rdata), 64'(0));
        chk("rst.resp", 64'({m_rresp, m_bresp}), 64'(0));
        chk("rst.saddr", 64'(s_araddr), 64'(0));
        clr_inputs();
        tick();
        rst_n = 1'b1;
        tick();

        // Fairness: both masters request continuously; pointer starts at 0 after reset.
        gcnt0 = 0;
        gcnt1 = 0;
        m_araddr = {32'h1000_0200, 32'h0000_0100};
        m_arvalid = 2'b11;
        m_rready = 2'b11;
        for (int n = 0; n < 8; n++) begin
            m = n % 2;
            a = (m == 1) ? 32'h1000_0200 : 32'h0000_0100;
            exp_q.push_back({a[31:8], 8'(n)});
            #1 chk("fair.grant", 64'(m_arready), 64'(1 << m));
            gcnt0 += int'(m_arready[0]);
            gcnt1 += int'(m_arready[1]);
            tick();
            #1 chk("fair.s_arvalid", 64'(s_arvalid), 64'(1 << m));
            s_arready[m] = 1'b1;
            tick();
            s_arready = '0;
            s_rvalid[m] = 1'b1;
            s_rdata[m*DW +: DW] = {s_araddr[m*AW+8 +: 24], 8'(n)};
            #1 chk("fair.m_rvalid", 64'(m_rvalid), 64'(1 << m));
            pop_chk("fair.rdata", 64'(m_rdata[m*DW +: DW]));
            tick();
            s_rvalid = '0;
        end
        clr_inputs();
        chk("fair.m0_grants", 64'(gcnt0), 64'(4));
        chk("fair.m1_grants", 64'(gcnt1), 64'(4));
        tick();

        rd_once(0, 32'h0000_0010, 0, 32'hDEAD_BEEF, "rd_basic");

        // Write to unmapped slave index 3: DECERR at cycle 1, slaves never see a valid.
        err_win = 1'b1;
        m_awaddr[AW +: AW] = 32'h3000_0000;
        m_wdata[DW +: DW]  = 32'h1111_2222;
        m_wstrb[SB +: SB]  = 4'hF;
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        #1 chk("werr.awready", 64'(m_awready), 64'(2'b10));
        chk("werr.wready", 64'(m_wready), 64'(2'b10));
        tick();
        m_awvalid = '0;
        m_wvalid  = '0;
        m_bready  = 2'b10;
        #1 chk("werr.bvalid", 64'(m_bvalid), 64'(2'b10));
        chk("werr.bresp", 64'(m_bresp), 64'(4'b1100));
        tick();
        m_bready = '0;
        #1 chk("werr.done", 64'(m_bvalid), 64'(0));
        err_win = 1'b0;
        chk("werr.no_slave_valid", 64'(stray), 64'(0));
        clr_inputs();

        // Concurrent: M0 reads S0 while M1 writes S1 in the same cycle.
        m_araddr[0 +: AW] = 32'h0000_0040;
        m_arvalid = 2'b01;
        m_awaddr[AW +: AW] = 32'h1000_0008;
        m_wdata[DW +: DW]  = 32'hA5A5_A5A5;
        m_wstrb[SB +: SB]  = 4'hF;
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        exp_q.push_back(32'hA5A5_A5A5);
        exp_q.push_back(32'h0000_000F);
        exp_q.push_back(32'h1234_5678);
        #1 chk("conc.arready", 64'(m_arready), 64'(2'b01));
        chk("conc.awready", 64'(m_awready), 64'(2'b10));
        chk("conc.wready", 64'(m_wready), 64'(2'b10));
        tick();
        m_arvalid = '0;
        m_awvalid = '0;
        m_wvalid  = '0;
        #1 chk("conc.s_arvalid", 64'(s_arvalid), 64'(2'b01));
        chk("conc.s_awvalid", 64'(s_awvalid), 64'(2'b10));
        chk("conc.s_wvalid", 64'(s_wvalid), 64'(2'b10));
        chk("conc.s_awaddr", 64'(s_awaddr[AW +: AW]), 64'(32'h1000_0008));
        pop_chk("conc.wdata", 64'(s_wdata[DW +: DW]));
        pop_chk("conc.wstrb", 64'(s_wstrb[SB +: SB]));
        s_arready = 2'b01;
        s_awready = 2'b10;
        s_wready  = 2'b10;
        tick();
        s_arready = '0;
        s_awready = '0;
        s_wready  = '0;
        s_rvalid  = 2'b01;
        s_rdata[0 +: DW] = 32'h1234_5678;
        s_bvalid  = 2'b10;
        m_rready  = 2'b01;
        m_bready  = 2'b10;
        #1 chk("conc.m_rvalid", 64'(m_rvalid), 64'(2'b01));
        pop_chk("conc.rdata", 64'(m_rdata[0 +: DW]));
        chk("conc.m_bvalid", 64'(m_bvalid), 64'(2'b10));
        chk("conc.bresp", 64'(m_bresp), 64'(0));
        tick();
        clr_inputs();
        #1 chk("conc.idle", 64'({m_rvalid, m_bvalid, s_awvalid, s_wvalid}), 64'(0));

        // Write backpressure: AW accepted 3 cycles late, W immediately.
        tick();
        bp_win = 1'b1;
        m_awaddr[0 +: AW] = 32'h1000_0010;
        m_wdata[0 +: DW]  = 32'h0BAD_F00D;
        m_wstrb[0 +: SB]  = 4'h3;
        m_awvalid = 2'b01;
        m_wvalid  = 2'b01;
        exp_q.push_back(32'h0BAD_F00D);
        #1 chk("bp.awready", 64'({m_awready, m_wready}), 64'(4'b0101));
        tick();
        m_awvalid = '0;
        m_wvalid  = '0;
        s_wready  = 2'b10;
        #1 chk("bp.c1_valids", 64'({s_awvalid, s_wvalid}), 64'(4'b1010));
        pop_chk("bp.wdata", 64'(s_wdata[DW +: DW]));
        tick();
        s_wready = '0;
        #1 chk("bp.c2_valids", 64'({s_awvalid, s_wvalid}), 64'(4'b1000));
        tick();
        #1 chk("bp.c3_awvalid", 64'(s_awvalid), 64'(2'b10));
        tick();
        s_awready = 2'b10;
        #1 chk("bp.c4_awvalid", 64'(s_awvalid), 64'(2'b10));
        tick();
        s_awready = '0;
        #1 chk("bp.c5_no_valid", 64'({s_awvalid, s_wvalid, m_bvalid}), 64'(0));
        s_bvalid = 2'b10;
        s_bresp[2 +: 2] = 2'b01;
        m_bready = 2'b01;
        #1 chk("bp.m_bvalid", 64'(m_bvalid), 64'(2'b01));
        chk("bp.bresp", 64'(m_bresp), 64'(4'b0001));
        tick();
        clr_inputs();
        #1 chk("bp.idle", 64'(m_bvalid), 64'(0));
        bp_win = 1'b0;
        chk("bp.awvalid_cycles", 64'(awv_cyc), 64'(4));
        chk("bp.wvalid_cycles", 64'(wv_cyc), 64'(1));
        chk("bp.bresp_count", 64'(b_hs), 64'(1));

        // Reset asserted while in the read data phase.
        tick();
        m_araddr[0 +: AW] = 32'h0000_0020;
        m_arvalid = 2'b01;
        tick();
        m_arvalid = '0;
        s_arready = 2'b01;
        tick();
        s_arready = '0;
        s_rvalid  = 2'b01;
        s_rdata[0 +: DW] = 32'h5555_AAAA;
        #1 chk("rstmid.rvalid_before", 64'(m_rvalid), 64'(2'b01));
        rst_n = 1'b0;
        #1 chk("rstmid.valid_ready", 64'({m_rvalid, m_arready, s_rready, s_arvalid}), 64'(0));
        chk("rstmid.rdata", 64'(m_rdata), 64'(0));
        clr_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        rd_once(0, 32'h0000_0000, 0, 32'hCAFE_F00D, "post_rst");

        chk("sb.drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
